// File: rtl/adder_tree_acc.sv
// adder_tree_acc
//   Pipelined adder tree that sums IDIM unsigned IWID-bit inputs, such as
//   unary bitstream bits from parallel channels. A valid tag travels with
//   the data. A windowed accumulator adds up ACC_WIN valid tree sums into
//   one binary total, which converts a unary stream into a binary count.
//
//   Tree level k (1-based, leaves are level 0) is registered when
//   k % BDEP == 0, so the tree latency is LAT = IDL2 / BDEP cycles. When
//   LAT is 0, o_sum is purely combinational from i_data.
//
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset
//   i_valid      qualifies i_data this cycle
//   i_data       IDIM operands, IWID bits each
//   i_clear      synchronous clear of the accumulator window (wins over a valid sum)
//   o_sum        tree sum (OWID bits), from i_data presented LAT cycles earlier
//   o_sum_valid  o_sum qualifier (i_valid delayed by LAT)
//   o_acc        most recent completed window total (not cleared by i_clear)
//   o_acc_valid  one-cycle pulse when o_acc updates
//   o_cnt        valid sums accumulated in the current window
module adder_tree_acc #(
  parameter  int IDIM    = 9,
  parameter  int IWID    = 1,
  parameter  int BDEP    = 2,
  parameter  int ACC_WIN = 256,
  localparam int IDL2    = $clog2(IDIM),
  localparam int OWID    = IWID + IDL2,
  localparam int CWID    = $clog2(ACC_WIN + 1),
  localparam int AWID    = OWID + CWID,
  localparam int LAT     = IDL2 / BDEP
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  input  logic [IWID-1:0] i_data [IDIM],
  input  logic            i_clear,
  output logic [OWID-1:0] o_sum,
  output logic            o_sum_valid,
  output logic [AWID-1:0] o_acc,
  output logic            o_acc_valid,
  output logic [CWID-1:0] o_cnt
);

  localparam int NPAD = 1 << IDL2;

  // Tree nodes use heap numbering: node 1 is the root, node p has children
  // 2p and 2p+1, and leaves occupy NPAD .. 2*NPAD-1. Level k therefore owns
  // nodes (NPAD >> k) .. (NPAD >> (k-1)) - 1.
  logic [OWID-1:0] node_c [1:2*NPAD-1];  // combinational value of each node
  logic [OWID-1:0] node_q [1:2*NPAD-1];  // registered copy (registered levels only)

  function automatic logic is_reg(input int k);
    return (k > 0) && (k % BDEP == 0);
  endfunction

  // NOTE: combinational logic uses blocking assignments and gives every
  // written variable a default first, so no latch can be inferred.
  always_comb begin
    for (int i = 1; i < 2 * NPAD; i++) node_c[i] = '0;
    // Leaves are zero-extended inputs; padding leaves stay at zero.
    for (int j = 0; j < IDIM; j++) node_c[NPAD + j] = OWID'(i_data[j]);
    // Walk from the leaves up so children are settled before parents read them.
    for (int k = 1; k <= IDL2; k++) begin
      for (int j = 0; j < (NPAD >> k); j++) begin
        int p;
        p = (NPAD >> k) + j;
        node_c[p] = (is_reg(k - 1) ? node_q[2 * p]     : node_c[2 * p])
                  + (is_reg(k - 1) ? node_q[2 * p + 1] : node_c[2 * p + 1]);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments; the pipeline
  // register array is reset element by element because every stage must
  // come out of reset at zero, unlike a storage memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 2 * NPAD; i++) node_q[i] <= '0;
    end else begin
      for (int k = 1; k <= IDL2; k++) begin
        if (is_reg(k)) begin
          for (int j = 0; j < (NPAD >> k); j++) begin
            node_q[(NPAD >> k) + j] <= node_c[(NPAD >> k) + j];
          end
        end
      end
    end
  end

  assign o_sum = is_reg(IDL2) ? node_q[1] : node_c[1];

  // Valid tag: a LAT-deep shift register that advances every cycle.
  generate
    if (LAT > 0) begin : g_vpipe
      logic [LAT-1:0] vld_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_q <= '0;
        else        vld_q <= LAT'({vld_q, i_valid});
      end
      assign o_sum_valid = vld_q[LAT-1];
    end else begin : g_vcomb
      assign o_sum_valid = i_valid;
    end
  endgenerate

  // Windowed accumulator. The closing sum goes straight into o_acc, so the
  // next window starts from an empty acc_q on the following cycle.
  logic [AWID-1:0] acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      o_cnt       <= '0;
      o_acc       <= '0;
      o_acc_valid <= 1'b0;
    end else begin
      o_acc_valid <= 1'b0;
      if (i_clear) begin
        acc_q <= '0;
        o_cnt <= '0;
      end else if (o_sum_valid) begin
        if (o_cnt == CWID'(ACC_WIN - 1)) begin
          o_acc       <= acc_q + AWID'(o_sum);
          o_acc_valid <= 1'b1;
          acc_q       <= '0;
          o_cnt       <= '0;
        end else begin
          acc_q <= acc_q + AWID'(o_sum);
          o_cnt <= o_cnt + 1'b1;
        end
      end
    end
  end

endmodule
